id_operand_unit: RTL and testbench
==================================

# id_operand_unit

Parametrised successor of the decode-stage operand path. The block owns the IF→ID pipeline register. It holds the instruction word across stalls, since synchronous instruction-SRAM data is only valid for one cycle. It selects each source operand from the register file or from NSRC forwarding sources under fixed priority, and raises a load-use interlock request when the winning producer's value is not yet available. It sits between IF and the ID decode logic and feeds the rs/rt operand fields of the ID→EX bus.

## Interface
- DW, 32, operand/data width
- NSRC, 3, number of forwarding sources; index 0 = youngest stage (EX), highest priority
- AW, 5, register address width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  6  codebase stall bus; stall[1] = IF/ID hold, stall[2] = ID hold
- if_pc  in  32  PC presented by IF
- if_ce  in  1  IF slot valid
- inst_sram_rdata  in  32  instruction SRAM read data (valid the cycle after the PC is captured)
- use_rs, use_rt  in  1 each  decoder says operand is consumed
- rf_rdata1, rf_rdata2  in  DW each  regfile read data for rs/rt
- fwd_we  in  NSRC  per-source write enable
- fwd_waddr  in  NSRC*AW  per-source destination, source i at [i*AW +: AW]
- fwd_wdata  in  NSRC*DW  per-source result, source i at [i*DW +: DW]
- fwd_pending  in  NSRC  source i's result not yet available (load in flight)
- id_valid  out  1  ID slot holds a real instruction
- id_pc  out  32  registered PC
- id_inst  out  32  instruction word of the ID slot
- opa, opb  out  DW each  resolved rs / rt operands
- stallreq  out  1  load-use interlock request to the stall controller
- lu_stall_cnt  out  32  saturating count of cycles with stallreq=1

## Operation
- Slot register {id_valid, id_pc}, decided in this priority order:
  - rst: 0.
  - stall[1]=1 and stall[2]=0: bubble, {0, 0}.
  - stall[1]=0: capture {if_ce, if_pc}.
  - Otherwise: hold.
- Instruction hold buffer: hold_inst (32 bit) and hold_v, both reset 0.
  - Cycle where stall[2]=1 and hold_v=0: latch inst_sram_rdata and set hold_v.
  - Any cycle where the slot register captures or bubbles: clear hold_v.
- id_inst = 0 if id_valid=0; else hold_inst if hold_v=1; else inst_sram_rdata.
- Fields: rs = id_inst[25:21], rt = id_inst[20:16].
- Operand resolution for each addr ∈ {rs, rt}:
  - addr = 0: result 0, and no source matches.
  - Otherwise, candidate i matches when fwd_we[i] & (fwd_waddr[i] == addr).
  - The lowest matching index wins and supplies fwd_wdata[i].
  - No match: regfile data is used.
- Load-use: stallreq = id_valid & ((use_rs & winner_rs exists & fwd_pending[winner_rs]) | (same for rt)).
  - Pending status of a lower-priority (older) source that lost arbitration is ignored.
- lu_stall_cnt: reset 0; +1 on every cycle with stallreq=1; saturates at 32'hFFFF_FFFF.
- Widths: opa/opb are exactly DW bits. fwd_waddr compares are exact AW-bit equality, with no truncation.

## Timing
- Slot-to-operand latency: the PC is captured at edge N. id_inst, opa, opb and stallreq are valid combinationally during cycle N+1.
- stallreq is combinational from the current-cycle forwarding inputs; no registered delay.
- Hold buffer: across a stall of any length, id_inst keeps the value sampled in the first stalled cycle. The hold_v set/clear edge must not create a one-cycle gap.
- Stall and bubble in the same cycle: stall[1]=1 with stall[2]=0 bubbles; the held instruction is discarded.
- Reset mid-stall: clears the slot, hold_v and the counter in the same edge; the next cycle outputs id_valid=0, id_inst=0, stallreq=0.
- Operands are recomputed every cycle. A stalled instruction picks up the forwarded value once the pending source drops fwd_pending, or once the value moves to an older source.

## Test plan
- Reset, then PC 0xBFC00000 with if_ce=1 and stall=0: the next cycle shows id_valid=1, id_pc=0xBFC00000, id_inst = SRAM word, stallreq=0, lu_stall_cnt=0.
- Forward priority: rs=5, with sources 0 and 2 both writing r5 (0x11 and 0x22) and regfile giving 0x33 → opa=0x11. Drop source 0 → opa=0x22. Drop all → opa=0x33. With rs=0 and a source writing r0 → opa=0.
- Load-use: source 0 writes rt=7 with fwd_pending=1 and use_rt=1 → stallreq=1. Drive stall[2:1]=2'b11 for 3 cycles while SRAM data changes → id_inst is held constant and lu_stall_cnt=3. Then clear pending → stallreq=0 and opb = forwarded value.
- Pending loser: source 1 (pending) and source 0 (not pending) both write r7 → stallreq=0, operand taken from source 0. Same setup with use_rt=0 and source 0 pending → stallreq=0.
- Bubble: stall[1]=1, stall[2]=0 → id_valid=0, id_inst=0, hold_v cleared. Assert rst during a held stall → all outputs 0 the next cycle.
- Counter saturation: preload (via force) lu_stall_cnt=32'hFFFF_FFFE and hold stallreq=1 for 3 cycles → count reads 32'hFFFF_FFFF and stays there.

Source files
------------

// File: rtl/id_operand_unit.sv
// Decode-stage operand path: IF->ID slot register, instruction hold buffer across
// stalls, prioritised operand forwarding and load-use interlock request.
module id_operand_unit #(
  parameter int DW   = 32,
  parameter int NSRC = 3,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic [31:0]          if_pc,
  input  logic                 if_ce,
  input  logic [31:0]          inst_sram_rdata,
  input  logic                 use_rs,
  input  logic                 use_rt,
  input  logic [DW-1:0]        rf_rdata1,
  input  logic [DW-1:0]        rf_rdata2,
  input  logic [NSRC-1:0]      fwd_we,
  input  logic [NSRC*AW-1:0]   fwd_waddr,
  input  logic [NSRC*DW-1:0]   fwd_wdata,
  input  logic [NSRC-1:0]      fwd_pending,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_inst,
  output logic [DW-1:0]        opa,
  output logic [DW-1:0]        opb,
  output logic                 stallreq,
  output logic [31:0]          lu_stall_cnt
);

  logic          valid_q, valid_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   hold_inst_q, hold_inst_d;
  logic          hold_v_q, hold_v_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          slot_upd_s;
  logic [AW-1:0] rs_addr_s, rt_addr_s;
  logic [DW+1:0] res_rs_s, res_rt_s;
  logic          stallreq_s;
  logic          unused_stall_s;

  assign unused_stall_s = ^{stall[5:3], stall[0]};

  // Returns {hit, pending, data}; loop runs oldest-first so the youngest match overrides.
  function automatic logic [DW+1:0] resolve(input logic [AW-1:0] addr,
                                             input logic [DW-1:0] rf_data);
    logic          hit;
    logic          pend;
    logic [DW-1:0] data;
    hit  = 1'b0;
    pend = 1'b0;
    data = rf_data;
    if (addr == '0) begin
      data = '0;
    end else begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
          hit  = 1'b1;
          pend = fwd_pending[i];
          data = fwd_wdata[i*DW +: DW];
        end else begin
          hit = hit;
        end
      end
    end
    return {hit, pend, data};
  endfunction

  // Instruction word of the ID slot: the SRAM word is only valid once, so a stall replays the held copy.
  always_comb begin
    if (!valid_q) begin
      id_inst = 32'd0;
    end else if (hold_v_q) begin
      id_inst = hold_inst_q;
    end else begin
      id_inst = inst_sram_rdata;
    end
  end

  assign rs_addr_s = AW'(id_inst[25:21]);
  assign rt_addr_s = AW'(id_inst[20:16]);

  // Operand selection and load-use detection from the winning producer only.
  always_comb begin
    res_rs_s   = resolve(rs_addr_s, rf_rdata1);
    res_rt_s   = resolve(rt_addr_s, rf_rdata2);
    stallreq_s = valid_q &
                 ((use_rs & res_rs_s[DW+1] & res_rs_s[DW]) |
                  (use_rt & res_rt_s[DW+1] & res_rt_s[DW]));
  end

  // Next-state logic for the slot, hold buffer and interlock counter.
  always_comb begin
    slot_upd_s = ~(stall[1] & stall[2]);
    if (stall[1] && !stall[2]) begin
      valid_d = 1'b0;
      pc_d    = 32'd0;
    end else if (!stall[1]) begin
      valid_d = if_ce;
      pc_d    = if_pc;
    end else begin
      valid_d = valid_q;
      pc_d    = pc_q;
    end

    if (slot_upd_s) begin
      hold_v_d    = 1'b0;
      hold_inst_d = hold_inst_q;
    end else if (stall[2] && !hold_v_q) begin
      hold_v_d    = 1'b1;
      hold_inst_d = inst_sram_rdata;
    end else begin
      hold_v_d    = hold_v_q;
      hold_inst_d = hold_inst_q;
    end

    if (stallreq_s && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      hold_inst_q <= 32'd0;
      hold_v_q    <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      hold_inst_q <= hold_inst_d;
      hold_v_q    <= hold_v_d;
      cnt_q       <= cnt_d;
    end
  end

  assign id_valid     = valid_q;
  assign id_pc        = pc_q;
  assign opa          = res_rs_s[DW-1:0];
  assign opb          = res_rt_s[DW-1:0];
  assign stallreq     = stallreq_s;
  assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_operand_unit.sv
// Self-checking bench for id_operand_unit: directed scenarios plus randomized
// traffic against a behavioural model of slot, hold and forwarding rules.
module tb_id_operand_unit;
  localparam int DW   = 32;
  localparam int NSRC = 3;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [5:0]           stall;
  logic [31:0]          if_pc;
  logic                 if_ce;
  logic [31:0]          inst_sram_rdata;
  logic                 use_rs, use_rt;
  logic [DW-1:0]        rf_rdata1, rf_rdata2;
  logic [NSRC-1:0]      fwd_we;
  logic [NSRC*AW-1:0]   fwd_waddr;
  logic [NSRC*DW-1:0]   fwd_wdata;
  logic [NSRC-1:0]      fwd_pending;
  logic                 id_valid;
  logic [31:0]          id_pc;
  logic [31:0]          id_inst;
  logic [DW-1:0]        opa, opb;
  logic                 stallreq;
  logic [31:0]          lu_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic        m_frozen = 1'b0;
  logic [31:0] m_word = 32'd0;
  logic [31:0] m_cnt = 32'd0;

  always #5 clk = ~clk;

  id_operand_unit #(.DW(DW), .NSRC(NSRC), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .if_ce(if_ce),
    .inst_sram_rdata(inst_sram_rdata), .use_rs(use_rs), .use_rt(use_rt),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .opa(opa), .opb(opb),
    .stallreq(stallreq), .lu_stall_cnt(lu_stall_cnt)
  );

  function automatic logic [31:0] exp_inst();
    if (!m_valid) return 32'd0;
    if (m_frozen) return m_word;
    return inst_sram_rdata;
  endfunction

  // First matching source in priority order wins; r0 is hardwired zero.
  function automatic void exp_operand(input logic [4:0] a, input logic [31:0] rf,
                                      output logic [31:0] val, output logic pend);
    val  = rf;
    pend = 1'b0;
    if (a == 5'd0) begin
      val = 32'd0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (fwd_we[i] && fwd_waddr[i*AW +: AW] == a) begin
          val  = fwd_wdata[i*DW +: DW];
          pend = fwd_pending[i];
          break;
        end
      end
    end
  endfunction

  function automatic logic exp_stallreq();
    logic [31:0] w, va, vb;
    logic pa, pb;
    w = exp_inst();
    exp_operand(w[25:21], rf_rdata1, va, pa);
    exp_operand(w[20:16], rf_rdata2, vb, pb);
    return m_valid & ((use_rs & pa) | (use_rt & pb));
  endfunction

  // Advance the model with the inputs present at the edge, then step past the edge.
  task automatic clock_edge();
    logic sr;
    sr = exp_stallreq();
    if (rst) begin
      m_valid = 1'b0; m_pc = 32'd0; m_frozen = 1'b0; m_word = 32'd0; m_cnt = 32'd0;
    end else begin
      if (sr && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (stall[1] && !stall[2]) begin
        m_valid = 1'b0; m_pc = 32'd0; m_frozen = 1'b0;
      end else if (!stall[1]) begin
        m_valid = if_ce; m_pc = if_pc; m_frozen = 1'b0;
      end else if (!m_frozen) begin
        m_frozen = 1'b1; m_word = inst_sram_rdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'd0; if_pc = 32'h1234_5678; if_ce = 1'b1;
    inst_sram_rdata = 32'hFFFF_FFFF; use_rs = 1'b1; use_rt = 1'b1;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0; fwd_we = 3'b111;
    fwd_waddr = {5'd31, 5'd31, 5'd31}; fwd_wdata = '0; fwd_pending = 3'b111;
    clock_edge();
    clock_edge();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
    n_vec++; if (id_inst !== 32'd0) begin n_err++; $display("FAIL reset_inst got=%h exp=0", id_inst); end
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL reset_stallreq got=%0b exp=0", stallreq); end
    n_vec++; if (lu_stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", lu_stall_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    stall = 6'd0; if_ce = 1'b1; if_pc = 32'hBFC0_0000; fwd_we = 3'b000; fwd_pending = 3'b000;
    clock_edge();
    inst_sram_rdata = 32'h3C08_1234;
    #1;
    n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid got=%0b exp=1", id_valid); end
    n_vec++; if (id_pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL fetch_pc got=%h exp=bfc00000", id_pc); end
    n_vec++; if (id_inst !== 32'h3C08_1234) begin n_err++; $display("FAIL fetch_inst got=%h exp=3c081234", id_inst); end
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL fetch_stallreq got=%0b exp=0", stallreq); end
    n_vec++; if (lu_stall_cnt !== 32'd0) begin n_err++; $display("FAIL fetch_cnt got=%h exp=0", lu_stall_cnt); end
  endtask

  task automatic test_forward_priority();
    inst_sram_rdata = {6'd0, 5'd5, 5'd0, 16'd0};
    use_rs = 1'b1; use_rt = 1'b0; rf_rdata1 = 32'h33; fwd_pending = 3'b000;
    fwd_waddr = {5'd5, 5'd9, 5'd5};
    fwd_wdata = {32'h22, 32'h99, 32'h11};
    fwd_we = 3'b101;
    #1;
    n_vec++; if (opa !== 32'h11) begin n_err++; $display("FAIL prio_src0 got=%h exp=11", opa); end
    fwd_we = 3'b100;
    #1;
    n_vec++; if (opa !== 32'h22) begin n_err++; $display("FAIL prio_src2 got=%h exp=22", opa); end
    fwd_we = 3'b000;
    #1;
    n_vec++; if (opa !== 32'h33) begin n_err++; $display("FAIL prio_rf got=%h exp=33", opa); end
    inst_sram_rdata = {6'd0, 5'd0, 5'd0, 16'd0};
    fwd_waddr = {5'd0, 5'd0, 5'd0}; fwd_wdata = {32'h0, 32'h0, 32'h44}; fwd_we = 3'b001;
    #1;
    n_vec++; if (opa !== 32'h0) begin n_err++; $display("FAIL prio_r0 got=%h exp=0", opa); end
  endtask

  task automatic test_load_use();
    logic [31:0] w1;
    w1 = {6'h23, 5'd0, 5'd7, 16'h0004};
    inst_sram_rdata = w1;
    use_rs = 1'b0; use_rt = 1'b1;
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd7}; fwd_wdata = {32'h0, 32'h0, 32'h77};
    fwd_pending = 3'b001;
    #1;
    n_vec++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL lu_req got=%0b exp=1", stallreq); end
    stall = 6'b000110;
    for (int k = 0; k < 3; k++) begin
      clock_edge();
      inst_sram_rdata = w1 ^ (32'h0100_0000 << k);
      #1;
      n_vec++; if (id_inst !== w1) begin n_err++; $display("FAIL lu_hold_inst k=%0d got=%h exp=%h", k, id_inst, w1); end
      n_vec++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL lu_hold_req k=%0d got=%0b exp=1", k, stallreq); end
    end
    n_vec++; if (lu_stall_cnt !== 32'd3) begin n_err++; $display("FAIL lu_cnt got=%0d exp=3", lu_stall_cnt); end
    fwd_pending = 3'b000;
    #1;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL lu_release got=%0b exp=0", stallreq); end
    n_vec++; if (opb !== 32'h77) begin n_err++; $display("FAIL lu_opb got=%h exp=77", opb); end
  endtask

  task automatic test_pending_loser();
    fwd_we = 3'b011; fwd_waddr = {5'd0, 5'd7, 5'd7};
    fwd_wdata = {32'h0, 32'hB1, 32'hA0}; fwd_pending = 3'b010; use_rt = 1'b1;
    #1;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL loser_req got=%0b exp=0", stallreq); end
    n_vec++; if (opb !== 32'hA0) begin n_err++; $display("FAIL loser_opb got=%h exp=a0", opb); end
    use_rt = 1'b0; fwd_pending = 3'b001;
    #1;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL unused_rt_req got=%0b exp=0", stallreq); end
  endtask

  task automatic test_bubble();
    stall = 6'b000010;
    clock_edge();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid got=%0b exp=0", id_valid); end
    n_vec++; if (id_pc !== 32'd0) begin n_err++; $display("FAIL bubble_pc got=%h exp=0", id_pc); end
    n_vec++; if (id_inst !== 32'd0) begin n_err++; $display("FAIL bubble_inst got=%h exp=0", id_inst); end
    stall = 6'd0; if_pc = 32'h0000_1000; if_ce = 1'b1;
    clock_edge();
    inst_sram_rdata = 32'h2222_5555;
    #1;
    n_vec++; if (id_inst !== 32'h2222_5555) begin n_err++; $display("FAIL bubble_holdclr got=%h exp=22225555", id_inst); end
  endtask

  task automatic test_reset_mid_stall();
    inst_sram_rdata = {6'h23, 5'd0, 5'd7, 16'h0008};
    use_rt = 1'b1; fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd7}; fwd_pending = 3'b001;
    stall = 6'b000110;
    clock_edge();
    inst_sram_rdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    clock_edge();
    inst_sram_rdata = {6'h23, 5'd0, 5'd7, 16'h000C};
    #1;
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%0b exp=0", id_valid); end
    n_vec++; if (id_pc !== 32'd0) begin n_err++; $display("FAIL rstmid_pc got=%h exp=0", id_pc); end
    n_vec++; if (id_inst !== 32'd0) begin n_err++; $display("FAIL rstmid_inst got=%h exp=0", id_inst); end
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL rstmid_req got=%0b exp=0", stallreq); end
    n_vec++; if (lu_stall_cnt !== 32'd0) begin n_err++; $display("FAIL rstmid_cnt got=%h exp=0", lu_stall_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    stall = 6'd0; if_ce = 1'b1; if_pc = 32'h0000_2000;
    clock_edge();
    inst_sram_rdata = {6'h23, 5'd0, 5'd7, 16'h0010};
    stall = 6'b000110;
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    n_vec++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL sat_req got=%0b exp=1", stallreq); end
    for (int k = 0; k < 3; k++) begin
      clock_edge();
      n_vec++; if (lu_stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_cnt k=%0d got=%h exp=ffffffff", k, lu_stall_cnt); end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, ei, ea, eb;
    logic pa, pb, es;
    logic [1:0] s21;
    int sel;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 19);
      s21 = (sel < 8) ? 2'b00 : (sel < 15) ? 2'b11 : (sel < 18) ? 2'b01 : 2'b10;
      stall = {3'($urandom), s21, 1'($urandom)};
      if_ce = 1'($urandom); if_pc = $urandom;
      r = $urandom;
      r[25:21] = 5'($urandom_range(0, 7));
      r[20:16] = 5'($urandom_range(0, 7));
      inst_sram_rdata = r;
      use_rs = 1'($urandom); use_rt = 1'($urandom);
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      for (int i = 0; i < NSRC; i++) begin
        fwd_we[i] = 1'($urandom);
        fwd_waddr[i*AW +: AW] = 5'($urandom_range(0, 7));
        fwd_wdata[i*DW +: DW] = $urandom;
        fwd_pending[i] = ($urandom_range(0, 2) == 0);
      end
      #1;
      ei = exp_inst();
      exp_operand(ei[25:21], rf_rdata1, ea, pa);
      exp_operand(ei[20:16], rf_rdata2, eb, pb);
      es = m_valid & ((use_rs & pa) | (use_rt & pb));
      n_vec++; if (id_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, id_valid, m_valid); end
      n_vec++; if (id_pc !== m_pc) begin n_err++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, id_pc, m_pc); end
      n_vec++; if (id_inst !== ei) begin n_err++; $display("FAIL rnd_inst c=%0d got=%h exp=%h", c, id_inst, ei); end
      n_vec++; if (opa !== ea) begin n_err++; $display("FAIL rnd_opa c=%0d got=%h exp=%h", c, opa, ea); end
      n_vec++; if (opb !== eb) begin n_err++; $display("FAIL rnd_opb c=%0d got=%h exp=%h", c, opb, eb); end
      n_vec++; if (stallreq !== es) begin n_err++; $display("FAIL rnd_stallreq c=%0d got=%0b exp=%0b", c, stallreq, es); end
      n_vec++; if (lu_stall_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c=%0d got=%h exp=%h", c, lu_stall_cnt, m_cnt); end
      clock_edge();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_forward_priority();
    test_load_use();
    test_pending_loser();
    test_bubble();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
